// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter with valid/ready load, registered serial output
// and frame markers. Optional enforced idle gap between frames.
module piso_serializer #(
    parameter int unsigned WIDTH      = 4,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter int unsigned GAP_CYCLES = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pdata,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             frame_start,
    output logic             done,
    output logic             busy
);

    localparam int unsigned     CntW    = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH);
    localparam logic [3:0]      GapLast = 4'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StShift, StGap} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [3:0]       gap_q, gap_d;
    logic             dout_q, dout_d;
    logic             valid_q, valid_d;
    logic             start_q, start_d;
    logic             done_q, done_d;
    logic             last_bit;
    logic             accept;

    // cnt_q holds the number of bits already presented, so WIDTH means the last bit is on dout
    assign last_bit   = (state_q == StShift) && (cnt_q == CntLast);
    assign load_ready = reset && ((state_q == StIdle) || (last_bit && (GAP_CYCLES == 0)));
    assign accept     = load_valid && load_ready;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        dout_d  = 1'b0;
        valid_d = 1'b0;
        start_d = 1'b0;
        done_d  = 1'b0;

        if (accept) begin
            state_d = StShift;
            dout_d  = MSB_FIRST ? pdata[WIDTH-1] : pdata[0];
            shreg_d = MSB_FIRST ? (pdata << 1) : (pdata >> 1);
            valid_d = 1'b1;
            start_d = 1'b1;
            cnt_d   = CntW'(1);
            gap_d   = 4'd0;
        end else begin
            case (state_q)
                StShift: begin
                    if (last_bit) begin
                        cnt_d   = '0;
                        shreg_d = '0;
                        state_d = (GAP_CYCLES != 0) ? StGap : StIdle;
                    end else begin
                        dout_d  = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
                        shreg_d = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
                        valid_d = 1'b1;
                        cnt_d   = cnt_q + CntW'(1);
                        done_d  = (cnt_q == CntLast - CntW'(1));
                    end
                end
                StGap: begin
                    if (gap_q == GapLast) begin
                        state_d = StIdle;
                        gap_d   = 4'd0;
                    end else begin
                        gap_d = gap_q + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            shreg_q <= '0;
            cnt_q   <= '0;
            gap_q   <= 4'd0;
            dout_q  <= 1'b0;
            valid_q <= 1'b0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            start_q <= start_d;
            done_q  <= done_d;
        end
    end

    assign dout        = dout_q;
    assign dout_valid  = valid_q;
    assign frame_start = start_q;
    assign done        = done_q;
    assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: two instances (MSB-first no gap, LSB-first gap 2) checked
// against a queue-of-expected-cycles reference model under directed and random stimulus.
module tb_piso_serializer;

    localparam int unsigned Gap0 = 0;
    localparam int unsigned Gap1 = 2;
    localparam bit          Msb0 = 1'b1;
    localparam bit          Msb1 = 1'b0;

    logic       clk;
    logic       reset;
    logic [3:0] pdata    [2];
    logic       lv       [2];
    logic       ready_w  [2];
    logic       dout_w   [2];
    logic       dv_w     [2];
    logic       fs_w     [2];
    logic       done_w   [2];
    logic       busy_w   [2];

    piso_serializer #(.WIDTH(4), .MSB_FIRST(Msb0), .GAP_CYCLES(Gap0)) u_dut0 (
        .clk        (clk),
        .reset      (reset),
        .pdata      (pdata[0]),
        .load_valid (lv[0]),
        .load_ready (ready_w[0]),
        .dout       (dout_w[0]),
        .dout_valid (dv_w[0]),
        .frame_start(fs_w[0]),
        .done       (done_w[0]),
        .busy       (busy_w[0])
    );

    piso_serializer #(.WIDTH(4), .MSB_FIRST(Msb1), .GAP_CYCLES(Gap1)) u_dut1 (
        .clk        (clk),
        .reset      (reset),
        .pdata      (pdata[1]),
        .load_valid (lv[1]),
        .load_ready (ready_w[1]),
        .dout       (dout_w[1]),
        .dout_valid (dv_w[1]),
        .frame_start(fs_w[1]),
        .done       (done_w[1]),
        .busy       (busy_w[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: each instance owns a queue of upcoming per-cycle outputs
    // {busy, done, frame_start, dout_valid, dout}; cur is what is on the outputs now.
    logic [4:0]  mq  [2][64];
    int unsigned hd  [2];
    int unsigned tl  [2];
    logic [4:0]  cur [2];

    logic        last_acc [2];
    logic [31:0] cap      [2];
    int          fscnt    [2];
    int          donecnt  [2];
    int          gapcnt   [2];
    int          dvcnt    [2];
    logic [3:0]  sipo;

    // Downstream 4-bit SIPO fed by the LSB-first instance
    always @(posedge clk or negedge reset) begin
        if (!reset)        sipo <= 4'd0;
        else if (dv_w[1])  sipo <= {dout_w[1], sipo[3:1]};
    end

    function automatic logic exp_ready(int i);
        int unsigned g = (i == 0) ? Gap0 : Gap1;
        return reset && (tl[i] == hd[i]) && (!cur[i][4] || (cur[i][3] && g == 0));
    endfunction

    task automatic model_clear(int i);
        hd[i]  = 0;
        tl[i]  = 0;
        cur[i] = 5'd0;
    endtask

    task automatic push_frame(int i, logic [3:0] w);
        logic        msb = (i == 0) ? Msb0 : Msb1;
        int unsigned g   = (i == 0) ? Gap0 : Gap1;
        for (int k = 0; k < 4; k++) begin
            logic b;
            b = msb ? w[3-k] : w[k];
            mq[i][tl[i] % 64] = {1'b1, (k == 3), (k == 0), 1'b1, b};
            tl[i]++;
        end
        for (int k = 0; k < int'(g); k++) begin
            mq[i][tl[i] % 64] = 5'b10000;
            tl[i]++;
        end
    endtask

    // One clock: check at negedge, advance model at posedge, return at posedge+1
    task automatic step();
        logic       acc [2];
        logic [3:0] pd  [2];
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check_eq($sformatf("out%0d", i),
                     {27'd0, busy_w[i], done_w[i], fs_w[i], dv_w[i], dout_w[i]},
                     {27'd0, cur[i]});
            check_eq($sformatf("rdy%0d", i), {31'd0, ready_w[i]}, {31'd0, exp_ready(i)});
            acc[i] = lv[i] && exp_ready(i);
            pd[i]  = pdata[i];
            if (dv_w[i]) begin
                cap[i] = {cap[i][30:0], dout_w[i]};
                dvcnt[i]++;
            end
            if (fs_w[i])                fscnt[i]++;
            if (done_w[i])              donecnt[i]++;
            if (busy_w[i] && !dv_w[i])  gapcnt[i]++;
        end
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            last_acc[i] = acc[i];
            if (!reset) begin
                model_clear(i);
            end else begin
                if (acc[i]) push_frame(i, pd[i]);
                if (tl[i] != hd[i]) begin
                    cur[i] = mq[i][hd[i] % 64];
                    hd[i]++;
                end else begin
                    cur[i] = 5'd0;
                end
            end
        end
        #1;
    endtask

    task automatic clear_stats();
        for (int i = 0; i < 2; i++) begin
            cap[i]     = 32'd0;
            fscnt[i]   = 0;
            donecnt[i] = 0;
            gapcnt[i]  = 0;
            dvcnt[i]   = 0;
        end
    endtask

    // Asynchronous reset pulled in the middle of a cycle
    task automatic apply_reset(int cycles);
        #2 reset = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            model_clear(i);
            check_eq($sformatf("rst_out%0d", i),
                     {27'd0, busy_w[i], done_w[i], fs_w[i], dv_w[i], dout_w[i]}, 32'd0);
            check_eq($sformatf("rst_rdy%0d", i), {31'd0, ready_w[i]}, 32'd0);
        end
        repeat (cycles) step();
        reset = 1'b1;
    endtask

    initial begin
        int nacc;
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            lv[i]       = 1'b0;
            pdata[i]    = 4'd0;
            last_acc[i] = 1'b0;
            model_clear(i);
        end
        clear_stats();
        @(posedge clk);
        #1;
        repeat (2) step();
        reset = 1'b1;
        #1;
        check_eq("rdy_after_rst", {31'd0, ready_w[0]}, 32'd1);

        // Single frame on both: MSB-first and LSB-first of 4'b1011
        clear_stats();
        lv[0] = 1'b1; pdata[0] = 4'b1011;
        lv[1] = 1'b1; pdata[1] = 4'b1011;
        step();
        lv[0] = 1'b0; lv[1] = 1'b0;
        repeat (8) step();
        check_eq("msb_bits", {28'd0, cap[0][3:0]}, 32'hB);
        check_eq("lsb_bits", {28'd0, cap[1][3:0]}, 32'hD);
        check_eq("sipo_word", {28'd0, sipo}, 32'hB);
        check_eq("fs_count", fscnt[0], 1);
        check_eq("done_count", donecnt[0], 1);
        check_eq("rdy_back", {31'd0, ready_w[0]}, 32'd1);

        // Back-to-back streaming, no gap
        clear_stats();
        nacc = 0;
        lv[0] = 1'b1; pdata[0] = 4'b1010;
        for (int c = 0; c < 14; c++) begin
            step();
            if (last_acc[0]) begin
                nacc++;
                if (nacc == 1) pdata[0] = 4'b0110;
                else           lv[0] = 1'b0;
            end
        end
        check_eq("b2b_bits", {24'd0, cap[0][7:0]}, 32'hA6);
        check_eq("b2b_accepts", nacc, 2);
        check_eq("b2b_fs", fscnt[0], 2);
        check_eq("b2b_idle", gapcnt[0], 0);

        // Two queued words with a 2-cycle gap
        clear_stats();
        nacc = 0;
        lv[1] = 1'b1; pdata[1] = 4'b0011;
        for (int c = 0; c < 22; c++) begin
            step();
            if (last_acc[1]) begin
                nacc++;
                if (nacc == 1) pdata[1] = 4'b1100;
                else           lv[1] = 1'b0;
            end
        end
        check_eq("gap_bits", {24'd0, cap[1][7:0]}, 32'hC3);
        check_eq("gap_cycles", gapcnt[1], 4);
        check_eq("gap_accepts", nacc, 2);

        // Reset mid-frame, then a clean frame
        clear_stats();
        lv[0] = 1'b1; pdata[0] = 4'b1111;
        step();
        lv[0] = 1'b0;
        repeat (2) step();
        apply_reset(2);
        check_eq("abort_done", donecnt[0], 0);
        clear_stats();
        lv[0] = 1'b1; pdata[0] = 4'b0001;
        step();
        lv[0] = 1'b0;
        repeat (6) step();
        check_eq("post_rst_bits", {28'd0, cap[0][3:0]}, 32'h1);
        check_eq("post_rst_done", donecnt[0], 1);

        // Random traffic: held valid while not ready, pdata noise while idle upstream
        for (int c = 0; c < 400; c++) begin
            if (c == 200) apply_reset(1);
            for (int i = 0; i < 2; i++) begin
                if (lv[i]) begin
                    if (last_acc[i]) begin
                        lv[i]    = ($urandom_range(0, 3) != 0);
                        pdata[i] = 4'($urandom);
                    end
                end else begin
                    pdata[i] = 4'($urandom);
                    lv[i]    = ($urandom_range(0, 2) == 0);
                end
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
